// File: rtl/score_keeper.sv
// score_keeper: game-progress FSM producing score, game-state flags and session best score.
module score_keeper #(
    parameter int WIN_SCORE   = 99,
    parameter int HOLD_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       round_pass,
    input  logic       round_fail,
    output logic [6:0] score,
    output logic       game_started,
    output logic       game_over,
    output logic       win,
    output logic [6:0] best_score
);
    typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;
    state_t      state_q, state_d;
    logic [6:0]  score_q, score_d, best_q, best_d, final_score;
    logic        started_q, started_d, over_q, over_d, win_q, win_d;
    logic [31:0] hold_q, hold_d;
    logic        reach_win, to_over;
    assign reach_win   = score_q + 7'd1 == 7'(WIN_SCORE);
    assign to_over     = state_q == PLAYING && (round_fail || (round_pass && reach_win));
    assign final_score = round_fail ? score_q : 7'(WIN_SCORE);
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        started_d = started_q;
        over_d    = over_q;
        win_d     = win_q;
        hold_d    = hold_q;
        best_d    = best_q;
        case (state_q)
            IDLE: if (start_pulse) begin
                state_d   = PLAYING;
                score_d   = 7'd0;
                started_d = 1'b1;
            end
            PLAYING: if (to_over) begin
                state_d = OVER;
                score_d = final_score;
                over_d  = 1'b1;
                win_d   = !round_fail;
                hold_d  = 32'd0;
                best_d  = final_score > best_q ? final_score : best_q;
            end else if (round_pass) begin
                score_d = score_q + 7'd1;
            end
            OVER: if (start_pulse) begin
                state_d = PLAYING;
                score_d = 7'd0;
                over_d  = 1'b0;
                win_d   = 1'b0;
            end else if (hold_q == 32'(HOLD_CYCLES - 1)) begin
                state_d   = IDLE;
                started_d = 1'b0;
                over_d    = 1'b0;
                win_d     = 1'b0;
            end else begin
                hold_d = hold_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            score_q   <= 7'd0;
            started_q <= 1'b0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
            hold_q    <= 32'd0;
            best_q    <= 7'd0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            started_q <= started_d;
            over_q    <= over_d;
            win_q     <= win_d;
            hold_q    <= hold_d;
            best_q    <= best_d;
        end
    end
    assign score        = score_q;
    assign game_started = started_q;
    assign game_over    = over_q;
    assign win          = win_q;
    assign best_score   = best_q;
endmodule
